// File: rtl/input_debounce_pkg.sv
// Shared constants for the switch/key debouncer: default timing, idle levels and counter widths.
package input_debounce_pkg;

  localparam int unsigned TICK_DIV_DEF     = 500;
  localparam int unsigned STABLE_TICKS_DEF = 100;
  localparam logic [3:0]  KEY_IDLE_DEF     = 4'b1111;
  localparam logic [3:0]  SW_IDLE_DEF      = 4'b0000;

  localparam int unsigned TICK_W = 16;
  localparam int unsigned STAB_W = 8;
  localparam int unsigned NUM_SW  = 4;
  localparam int unsigned NUM_KEY = 4;

endpackage

// File: rtl/input_debounce_if.sv
// Pin-side bundle of the debouncer: raw switch/key inputs, clean levels, key events and tick.
interface input_debounce_if;
  import input_debounce_pkg::*;

  logic [NUM_SW-1:0]  switches_raw;
  logic [NUM_KEY-1:0] keys_raw;
  logic [NUM_SW-1:0]  switches;
  logic [NUM_KEY-1:0] keys;
  logic [NUM_KEY-1:0] key_press;
  logic [NUM_KEY-1:0] key_release;
  logic               tick;

  modport master (
    output switches_raw, keys_raw,
    input  switches, keys, key_press, key_release, tick
  );

  modport slave (
    input  switches_raw, keys_raw,
    output switches, keys, key_press, key_release, tick
  );

endinterface

// File: rtl/debounce_chan.sv
// One debounced input: two-flop synchroniser, stability counter advanced on the shared tick,
// accepted level and registered rise/fall event pulses.
module debounce_chan
  import input_debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  input  logic idle,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam logic [STAB_W-1:0] CntMax = STAB_W'(STABLE_TICKS - 1);

  logic              s1;
  logic              s2;
  logic [STAB_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= idle;
      s2   <= idle;
      out  <= idle;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // Any cycle where the synchronised level agrees with the output restarts the count.
      if (s2 == out) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CntMax) begin
          out  <= s2;
          cnt  <= '0;
          rise <= s2;
          fall <= ~s2;
        end else begin
          cnt <= cnt + STAB_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/input_debounce.sv
// Debouncer for four switches and four active-low keys sharing one sample-tick prescaler.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
  parameter logic [3:0]  KEY_IDLE     = KEY_IDLE_DEF,
  parameter logic [3:0]  SW_IDLE      = SW_IDLE_DEF
) (
  input logic            clk,
  input logic            rst,
  input_debounce_if.slave bus
);

  localparam logic [TICK_W-1:0] TickMax = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0]  tick_cnt;
  logic [TICK_W-1:0]  tick_nxt;
  logic               tick_strobe;
  logic [NUM_SW-1:0]  sw_out;
  logic [NUM_SW-1:0]  unused_sw_rise;
  logic [NUM_SW-1:0]  unused_sw_fall;
  logic [NUM_KEY-1:0] key_out;
  logic [NUM_KEY-1:0] key_rise;
  logic [NUM_KEY-1:0] key_fall;

  always_comb begin
    tick_nxt = (tick_cnt == TickMax) ? '0 : tick_cnt + TICK_W'(1);
  end

  // Tick is registered so it is high exactly while tick_cnt sits at TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      tick_strobe <= 1'b0;
    end else begin
      tick_cnt    <= tick_nxt;
      tick_strobe <= (tick_nxt == TickMax);
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_strobe),
      .raw  (bus.switches_raw[i]),
      .idle (SW_IDLE[i]),
      .out  (sw_out[i]),
      .rise (unused_sw_rise[i]),
      .fall (unused_sw_fall[i])
    );
  end

  for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_strobe),
      .raw  (bus.keys_raw[i]),
      .idle (KEY_IDLE[i]),
      .out  (key_out[i]),
      .rise (key_rise[i]),
      .fall (key_fall[i])
    );
  end

  // Keys are active-low: a falling level is a press.
  assign bus.switches    = sw_out;
  assign bus.keys        = key_out;
  assign bus.key_press   = key_fall;
  assign bus.key_release = key_rise;
  assign bus.tick        = tick_strobe;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: settled-level vector table plus multi-cycle corner sequences.
module tb_input_debounce;
  import input_debounce_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  input_debounce_if bus ();
  input_debounce_if bus1 ();

  input_debounce #(
    .TICK_DIV(4), .STABLE_TICKS(3), .KEY_IDLE(4'b1111), .SW_IDLE(4'b0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  input_debounce #(
    .TICK_DIV(1), .STABLE_TICKS(1), .KEY_IDLE(4'b1111), .SW_IDLE(4'b0000)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [3:0] sw_raw;
    logic [3:0] key_raw;
    logic [3:0] exp_sw;
    logic [3:0] exp_keys;
  } vec_t;

  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_tests++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  initial begin
    int found;
    int lat;
    int cnt_a;
    int cnt_b;

    vecs[0] = '{4'b0101, 4'b1111, 4'b0101, 4'b1111};
    vecs[1] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010};
    vecs[2] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
    vecs[3] = '{4'b0000, 4'b0110, 4'b0000, 4'b0110};
    vecs[4] = '{4'b0011, 4'b1111, 4'b0011, 4'b1111};
    vecs[5] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};

    rst = 1'b1;
    bus.switches_raw  = 4'b0000;
    bus.keys_raw      = 4'b1111;
    bus1.switches_raw = 4'b0000;
    bus1.keys_raw     = 4'b1111;
    repeat (3) step();
    check("reset switches", bus.switches, 4'b0000);
    check("reset keys", bus.keys, 4'b1111);
    check("reset key_press", bus.key_press, 4'b0000);
    check("reset key_release", bus.key_release, 4'b0000);
    check("reset tick", bus.tick, 1'b0);
    check("reset tick dut1", bus1.tick, 1'b0);
    rst = 1'b0;

    // Tick period of 4 cycles
    cnt_a = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.tick) cnt_a++;
    end
    check("tick count over 40 cycles", cnt_a, 10);

    // Settled-level table
    for (int v = 0; v < 6; v++) begin
      bus.switches_raw = vecs[v].sw_raw;
      bus.keys_raw     = vecs[v].key_raw;
      repeat (20) step();
      check($sformatf("vec%0d switches", v), bus.switches, vecs[v].exp_sw);
      check($sformatf("vec%0d keys", v), bus.keys, vecs[v].exp_keys);
      check($sformatf("vec%0d no pulses", v), {bus.key_press, bus.key_release}, 8'h00);
    end

    // 1: single key press latency and one-cycle pulse
    bus.keys_raw = 4'b1110;
    found = 0; lat = 0; cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus.key_press != 4'b0000) cnt_a++;
      if (bus.key_release != 4'b0000) cnt_b++;
      if (found == 0 && bus.keys[0] == 1'b0) begin
        found = 1;
        lat   = c;
        check("t1 press value", bus.key_press, 4'b0001);
      end
    end
    check("t1 accepted", found, 1);
    check_range("t1 latency", lat, 10, 14);
    check("t1 press cycles", cnt_a, 1);
    check("t1 release cycles", cnt_b, 0);
    check("t1 keys", bus.keys, 4'b1110);
    bus.keys_raw = 4'b1111;
    repeat (20) step();
    check("t1 restore keys", bus.keys, 4'b1111);

    // 2: short glitch on key 2 is rejected
    cnt_a = 0;
    bus.keys_raw = 4'b1011;
    repeat (6) begin
      step();
      if (bus.keys != 4'b1111 || bus.key_press != 0 || bus.key_release != 0) cnt_a++;
    end
    bus.keys_raw = 4'b1111;
    repeat (20) begin
      step();
      if (bus.keys != 4'b1111 || bus.key_press != 0 || bus.key_release != 0) cnt_a++;
    end
    check("t2 glitch cycles with output change", cnt_a, 0);

    // 3: bouncing switch 1 then steady high
    cnt_a = 0;
    for (int k = 0; k < 10; k++) begin
      bus.switches_raw = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (3) begin
        step();
        if (bus.switches[1] != 1'b0) cnt_a++;
      end
    end
    check("t3 switch moved during bounce", cnt_a, 0);
    bus.switches_raw = 4'b0010;
    found = 0; lat = 0;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      step();
      if (bus.switches == 4'b0010) begin
        found = 1;
        lat   = c;
      end
    end
    check("t3 accepted", found, 1);
    check_range("t3 latency", lat, 1, 14);
    check("t3 no key pulses", {bus.key_press, bus.key_release}, 8'h00);
    bus.switches_raw = 4'b0000;
    repeat (20) step();

    // 4: all four keys released together
    bus.keys_raw = 4'b0000;
    repeat (20) step();
    check("t4 keys low", bus.keys, 4'b0000);
    bus.keys_raw = 4'b1111;
    found = 0; lat = 0;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      step();
      if (bus.keys != 4'b0000) begin
        found = 1;
        lat   = c;
        check("t4 keys released together", bus.keys, 4'b1111);
        check("t4 release pulse", bus.key_release, 4'b1111);
        check("t4 no press", bus.key_press, 4'b0000);
      end
    end
    check("t4 accepted", found, 1);
    check_range("t4 latency", lat, 10, 14);
    step();
    check("t4 release one cycle", bus.key_release, 4'b0000);

    // 5: reset mid-count discards progress
    bus.keys_raw = 4'b0000;
    repeat (6) step();
    check("t5 keys before reset", bus.keys, 4'b1111);
    rst = 1'b1;
    step();
    check("t5 keys at reset", bus.keys, 4'b1111);
    check("t5 no pulse at reset", {bus.key_press, bus.key_release}, 8'h00);
    rst = 1'b0;
    cnt_a = 0;
    repeat (10) begin
      step();
      if (bus.keys != 4'b1111 || bus.key_press != 0 || bus.key_release != 0) cnt_a++;
    end
    check("t5 idle after reset", cnt_a, 0);
    found = 0; cnt_b = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus.key_press != 4'b0000) begin
        cnt_b++;
        check("t5 press value", bus.key_press, 4'b1111);
      end
      if (found == 0 && bus.keys == 4'b0000) found = 1;
    end
    check("t5 keys reach low", found, 1);
    check("t5 press pulses", cnt_b, 1);
    bus.keys_raw = 4'b1111;

    // 6: TICK_DIV=1, STABLE_TICKS=1 instance
    cnt_a = 0;
    repeat (8) begin
      step();
      if (bus1.tick != 1'b1) cnt_a++;
    end
    check("t6 tick every cycle", cnt_a, 0);
    bus1.keys_raw = 4'b0111;
    step();
    check("t6 fall +1", bus1.keys[3], 1'b1);
    step();
    check("t6 fall +2", bus1.keys[3], 1'b1);
    step();
    check("t6 fall +3", bus1.keys[3], 1'b0);
    check("t6 press pulse", bus1.key_press, 4'b1000);
    bus1.keys_raw = 4'b1111;
    step();
    step();
    check("t6 rise +2", bus1.keys[3], 1'b0);
    step();
    check("t6 rise +3", bus1.keys[3], 1'b1);
    check("t6 release pulse", bus1.key_release, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
